// File: rtl/enc8b10b_pkg.sv
// Shared 8B/10B link-layer constants: control characters and the transmit scheduler states.
package enc8b10b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
    localparam logic [7:0] K30_7 = 8'hFE;  // abort

    typedef enum logic [2:0] {
        TRAIN,
        IDLE,
        DATA,
        EOF,
        ABORT
    } tx_state_e;

endpackage

// File: rtl/comma_interval_cnt.sv
// Saturating count of non-comma characters since the last K28.5; flags when a comma must go out next.
module comma_interval_cnt #(
    parameter int COMMA_INTERVAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic is_comma,
    input  logic advance,
    output logic comma_due
);

    localparam int CW = $clog2(COMMA_INTERVAL);
    localparam logic [CW-1:0] CMAX = CW'(COMMA_INTERVAL - 1);

    logic [CW-1:0] ccnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ccnt <= '0;
        end else if (advance) begin
            if (is_comma)
                ccnt <= '0;
            else if (ccnt != CMAX)
                ccnt <= ccnt + CW'(1);
        end
    end

    assign comma_due = (ccnt == CMAX);

endmodule

// File: rtl/enc_tx_sequencer.sv
// Transmit scheduler ahead of the 8B/10B encoder: training, idle commas, framed payload,
// and forced periodic K28.5 for receiver comma alignment.
module enc_tx_sequencer
    import enc8b10b_pkg::*;
#(
    parameter int TRAIN_LEN      = 16,
    parameter int COMMA_INTERVAL = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_retrain,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  enc_data,
    output logic        enc_k,
    output logic        enc_valid,
    output logic        link_up,
    output logic [15:0] frame_cnt
);

    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TRAIN_LEN - 1);

    tx_state_e     state;
    logic [TW-1:0] tcnt;
    logic          comma_due;
    logic          xfer;
    logic          sof_go;
    logic          eof_go;
    logic          emit_comma;

    assign s_ready = !rst && (state == DATA) && !comma_due && !tx_retrain;
    assign xfer    = s_valid && s_ready;
    assign sof_go  = (state == IDLE) && !tx_retrain && s_valid && !comma_due;
    assign eof_go  = (state == EOF) && !tx_retrain && !comma_due;

    // Anything that is not SOF, payload, EOF or ABORT goes out as K28.5.
    assign emit_comma = !(sof_go || xfer || eof_go || (state == ABORT));

    // A character leaves every cycle out of reset, so the counter always advances.
    comma_interval_cnt #(
        .COMMA_INTERVAL(COMMA_INTERVAL)
    ) u_ccnt (
        .clk      (clk),
        .rst      (rst),
        .is_comma (emit_comma),
        .advance  (1'b1),
        .comma_due(comma_due)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TRAIN;
            tcnt      <= '0;
            enc_data  <= K28_5;
            enc_k     <= 1'b1;
            enc_valid <= 1'b0;
            link_up   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            enc_valid <= 1'b1;
            enc_data  <= K28_5;
            enc_k     <= 1'b1;
            case (state)
                TRAIN: begin
                    if (tx_retrain) begin
                        tcnt    <= '0;
                        link_up <= 1'b0;
                    end else if (tcnt == TLAST) begin
                        tcnt    <= '0;
                        link_up <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                IDLE: begin
                    if (tx_retrain) begin
                        tcnt    <= '0;
                        link_up <= 1'b0;
                        state   <= TRAIN;
                    end else if (sof_go) begin
                        enc_data <= K27_7;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // Retrain already masked s_ready, so a pending last byte is dropped.
                    if (tx_retrain) begin
                        state <= ABORT;
                    end else if (xfer) begin
                        enc_data <= s_data;
                        enc_k    <= 1'b0;
                        if (s_last)
                            state <= EOF;
                    end
                end
                EOF: begin
                    if (tx_retrain) begin
                        state <= ABORT;
                    end else if (eof_go) begin
                        enc_data  <= K29_7;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                ABORT: begin
                    enc_data <= K30_7;
                    tcnt     <= '0;
                    link_up  <= 1'b0;
                    state    <= TRAIN;
                end
                default: begin
                    state <= TRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_tx_sequencer.sv
// Bench for enc_tx_sequencer: two instances (COMMA_INTERVAL 64 and 4) against a rule-level model,
// plus directed vector tables and hand sequences.
module tb_enc_tx_sequencer;

    localparam int TL = 16;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SOF = 8'hFB;
    localparam logic [7:0] K_EOF = 8'hFD;
    localparam logic [7:0] K_ABT = 8'hFE;

    localparam int M_TRAIN = 0;
    localparam int M_IDLE  = 1;
    localparam int M_FRAME = 2;
    localparam int M_CLOSE = 3;
    localparam int M_ABORT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s[2];
    logic       rt_s[2];
    logic [7:0] data_s[2];
    logic       valid_s[2];
    logic       last_s[2];

    logic [7:0]  ed_a, ed_b;
    logic        ek_a, ek_b, ev_a, ev_b, lu_a, lu_b, rdy_a, rdy_b;
    logic [15:0] fc_a, fc_b;

    enc_tx_sequencer #(.TRAIN_LEN(TL), .COMMA_INTERVAL(64)) dut_a (
        .clk(clk), .rst(rst_s[0]), .tx_retrain(rt_s[0]), .s_data(data_s[0]),
        .s_valid(valid_s[0]), .s_last(last_s[0]), .s_ready(rdy_a), .enc_data(ed_a),
        .enc_k(ek_a), .enc_valid(ev_a), .link_up(lu_a), .frame_cnt(fc_a)
    );

    enc_tx_sequencer #(.TRAIN_LEN(TL), .COMMA_INTERVAL(4)) dut_b (
        .clk(clk), .rst(rst_s[1]), .tx_retrain(rt_s[1]), .s_data(data_s[1]),
        .s_valid(valid_s[1]), .s_last(last_s[1]), .s_ready(rdy_b), .enc_data(ed_b),
        .enc_k(ek_b), .enc_valid(ev_b), .link_up(lu_b), .frame_cnt(fc_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: spec rules on plain integers ----------------
    typedef struct {
        int         mode;
        int         trained;
        int         run;      // non-comma characters since the last comma
        int         frames;
        bit         lu;
        bit         vld;
        logic [7:0] d;
        bit         k;
    } mdl_t;

    mdl_t m[2];
    int   obs_run[2];
    int   obs_max[2];

    function automatic int ci(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.mode = M_TRAIN; r.trained = 0; r.run = 0; r.frames = 0;
        r.lu = 0; r.vld = 0; r.d = K_COM; r.k = 1;
        return r;
    endfunction

    function automatic bit mdl_ready(input int i);
        return !rst_s[i] && m[i].mode == M_FRAME && m[i].run < ci(i) - 1 && !rt_s[i];
    endfunction

    task automatic mdl_step(input int i);
        logic [7:0] c;
        bit ck, due, rdy;
        if (rst_s[i]) begin
            m[i] = mdl_reset();
            return;
        end
        due = (m[i].run >= ci(i) - 1);
        rdy = mdl_ready(i);
        c = K_COM;
        ck = 1;
        case (m[i].mode)
            M_TRAIN: begin
                if (rt_s[i]) m[i].trained = 0;
                else begin
                    m[i].trained++;
                    if (m[i].trained == TL) begin
                        m[i].mode = M_IDLE; m[i].lu = 1; m[i].trained = 0;
                    end
                end
            end
            M_IDLE: begin
                if (rt_s[i]) begin
                    m[i].mode = M_TRAIN; m[i].trained = 0; m[i].lu = 0;
                end else if (valid_s[i] && !due) begin
                    c = K_SOF; m[i].mode = M_FRAME;
                end
            end
            M_FRAME: begin
                if (rt_s[i]) m[i].mode = M_ABORT;
                else if (rdy && valid_s[i]) begin
                    c = data_s[i]; ck = 0;
                    if (last_s[i]) m[i].mode = M_CLOSE;
                end
            end
            M_CLOSE: begin
                if (rt_s[i]) m[i].mode = M_ABORT;
                else if (!due) begin
                    c = K_EOF; m[i].frames = (m[i].frames + 1) % 65536; m[i].mode = M_IDLE;
                end
            end
            default: begin
                c = K_ABT; m[i].mode = M_TRAIN; m[i].trained = 0; m[i].lu = 0;
            end
        endcase
        m[i].run = (ck && c == K_COM) ? 0 : m[i].run + 1;
        m[i].d = c; m[i].k = ck; m[i].vld = 1;
    endtask

    function automatic logic [31:0] dut_out(input int i);
        return (i == 0) ? {5'd0, ev_a, ek_a, ed_a, lu_a, fc_a} : {5'd0, ev_b, ek_b, ed_b, lu_b, fc_b};
    endfunction

    function automatic logic [31:0] mdl_out(input int i);
        return {5'd0, m[i].vld, m[i].k, m[i].d, m[i].lu, 16'(m[i].frames)};
    endfunction

    function automatic logic dut_rdy(input int i);
        return (i == 0) ? rdy_a : rdy_b;
    endfunction

    // One clock: check ready against the model, advance the model, check registered outputs.
    task automatic tick();
        logic [31:0] o;
        #1;
        for (int i = 0; i < 2; i++) chk(i == 0 ? "mdl_rdy_a" : "mdl_rdy_b", 32'(dut_rdy(i)), 32'(mdl_ready(i)));
        for (int i = 0; i < 2; i++) mdl_step(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            o = dut_out(i);
            chk(i == 0 ? "mdl_out_a" : "mdl_out_b", o, mdl_out(i));
            if (o[26] && !(o[25] && o[24:17] == K_COM)) obs_run[i]++;
            else obs_run[i] = 0;
            if (obs_run[i] > obs_max[i]) obs_max[i] = obs_run[i];
        end
    endtask

    task automatic idle_in(input int i);
        rt_s[i] = 0; valid_s[i] = 0; last_s[i] = 0; data_s[i] = 8'h00;
    endtask

    // ---------------- directed vector table (instance a) ----------------
    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         l;
        bit         r;
        bit         er;
        logic [7:0] ed;
        bit         ek;
        bit         elu;
        logic [15:0] efc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input logic [7:0] d, input bit l, input bit r,
                       input bit er, input logic [7:0] ed, input bit ek, input bit elu,
                       input logic [15:0] efc);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.r = r; x.er = er; x.ed = ed; x.ek = ek; x.elu = elu; x.efc = efc;
        tbl.push_back(x);
    endtask

    logic [7:0] exp3[16];
    bit         k3[16];

    initial begin
        int idx;
        bit took;

        // 3-byte frame
        add(1, 8'h11, 0, 0, 0, K_SOF, 1, 1, 0);
        add(1, 8'h11, 0, 0, 1, 8'h11, 0, 1, 0);
        add(1, 8'h22, 0, 0, 1, 8'h22, 0, 1, 0);
        add(1, 8'h33, 1, 0, 1, 8'h33, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, K_EOF, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, K_COM, 1, 1, 1);
        // underrun for two cycles mid-frame
        add(1, 8'h41, 0, 0, 0, K_SOF, 1, 1, 1);
        add(1, 8'h41, 0, 0, 1, 8'h41, 0, 1, 1);
        add(0, 8'h00, 0, 0, 1, K_COM, 1, 1, 1);
        add(0, 8'h00, 0, 0, 1, K_COM, 1, 1, 1);
        add(1, 8'h42, 1, 0, 1, 8'h42, 0, 1, 1);
        add(0, 8'h00, 0, 0, 0, K_EOF, 1, 1, 2);
        add(0, 8'h00, 0, 0, 0, K_COM, 1, 1, 2);
        // retrain on the last byte: filler, abort, full retraining
        add(1, 8'h51, 0, 0, 0, K_SOF, 1, 1, 2);
        add(1, 8'h51, 0, 0, 1, 8'h51, 0, 1, 2);
        add(1, 8'h52, 1, 1, 0, K_COM, 1, 1, 2);
        add(0, 8'h00, 0, 0, 0, K_ABT, 1, 0, 2);
        for (int j = 0; j < TL; j++) add(0, 8'h00, 0, 0, 0, K_COM, 1, (j == TL - 1), 2);

        exp3 = '{K_SOF, 8'h01, 8'h02, K_COM, 8'h03, 8'h04, 8'h05, K_COM,
                 8'h06, 8'h07, 8'h08, K_COM, 8'h09, 8'h0A, K_EOF, K_COM};
        k3   = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};

        for (int i = 0; i < 2; i++) begin
            idle_in(i);
            rst_s[i] = 1;
            m[i] = mdl_reset();
            obs_run[i] = 0;
            obs_max[i] = 0;
        end

        @(posedge clk);
        #1;
        tick();
        chk("reset_out_a", dut_out(0), {5'd0, 1'b0, 1'b1, K_COM, 1'b0, 16'd0});
        chk("reset_rdy_a", 32'(rdy_a), 32'd0);

        // training: exactly TL commas, link_up with the last one
        rst_s[0] = 0;
        rst_s[1] = 0;
        for (int j = 0; j < TL; j++) begin
            tick();
            chk("train_a", {22'd0, ev_a, ek_a, ed_a, lu_a}, {22'd0, 1'b1, 1'b1, K_COM, 1'(j == TL - 1)});
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("idle_a", {23'd0, ek_a, ed_a, lu_a}, {23'd0, 1'b1, K_COM, 1'b1});
        end

        // vector table on instance a
        foreach (tbl[n]) begin
            valid_s[0] = tbl[n].v; data_s[0] = tbl[n].d; last_s[0] = tbl[n].l; rt_s[0] = tbl[n].r;
            #1;
            chk("vec_rdy", 32'(rdy_a), 32'(tbl[n].er));
            tick();
            chk("vec_out", {6'd0, ek_a, ed_a, lu_a, fc_a}, {6'd0, tbl[n].ek, tbl[n].ed, tbl[n].elu, tbl[n].efc});
        end
        idle_in(0);

        // forced commas with COMMA_INTERVAL=4 on instance b
        idx = 0;
        for (int j = 0; j < 16; j++) begin
            valid_s[1] = (idx < 10);
            data_s[1]  = 8'(idx + 1);
            last_s[1]  = (idx == 9);
            #1;
            took = rdy_b && valid_s[1];
            tick();
            chk("ci4_stream", {23'd0, ek_b, ed_b}, {23'd0, k3[j], exp3[j]});
            if (took) idx++;
        end
        idle_in(1);
        chk("ci4_bytes", 32'(idx), 32'd10);
        chk("ci4_frames", 32'(fc_b), 32'd1);

        // reset in the middle of a frame on instance a
        valid_s[0] = 1; data_s[0] = 8'h77; last_s[0] = 0;
        tick();
        tick();
        rst_s[0] = 1;
        #1;
        chk("rst_rdy", 32'(rdy_a), 32'd0);
        tick();
        chk("rst_mid_out", dut_out(0), {5'd0, 1'b0, 1'b1, K_COM, 1'b0, 16'd0});
        rst_s[0] = 0;
        idle_in(0);

        // randomized traffic on both instances
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 2; i++) begin
                rst_s[i]   = ($urandom_range(0, 799) == 0);
                rt_s[i]    = ($urandom_range(0, 99) == 0);
                valid_s[i] = ($urandom_range(0, 3) != 0);
                data_s[i]  = 8'($urandom);
                last_s[i]  = ($urandom_range(0, 5) == 0);
            end
            tick();
        end

        chk("max_run_a", 32'(obs_max[0] <= ci(0) - 1), 32'd1);
        chk("max_run_b", 32'(obs_max[1] <= ci(1) - 1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
